mips_load_store_unit: RTL



---
 rtl/mips_lsu_pkg.sv | 15 +
 rtl/mips_lsu_lane.sv | 43 ++++
 rtl/mips_load_store_unit.sv | 159 +++++++++++++++
 3 files changed

// File: rtl/mips_lsu_pkg.sv
// rtl/mips_lsu_pkg.sv - size encodings and FSM states for the MIPS load/store unit
package mips_lsu_pkg;

    localparam logic [1:0] SZ_BYTE = 2'b00;
    localparam logic [1:0] SZ_HALF = 2'b01;
    localparam logic [1:0] SZ_WORD = 2'b10;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_READ,
        ST_WRITE,
        ST_RESP
    } lsu_state_e;

endpackage

// File: rtl/mips_lsu_lane.sv
// rtl/mips_lsu_lane.sv - big-endian store lane merge and load extract/extend
module mips_lsu_lane
    import mips_lsu_pkg::*;
(
    input  logic [1:0]  size,
    input  logic [1:0]  offset,
    input  logic        is_unsigned,
    input  logic [31:0] rd_word,
    input  logic [31:0] st_data,
    output logic [31:0] merged_word,
    output logic [31:0] load_word
);

    // Big-endian: offset 0 is the most significant lane, so shift = (3 - offset) lanes.
    logic [4:0]  byte_sh;
    logic [4:0]  half_sh;
    logic [7:0]  ld_byte;
    logic [15:0] ld_half;

    assign byte_sh = {~offset, 3'b000};
    assign half_sh = {~offset[1], 4'b0000};
    assign ld_byte = 8'(rd_word >> byte_sh);
    assign ld_half = 16'(rd_word >> half_sh);

    always_comb begin
        merged_word = st_data;
        load_word   = rd_word;
        case (size)
            SZ_BYTE: begin
                merged_word = (rd_word & ~(32'h0000_00FF << byte_sh))
                            | ({24'h0, st_data[7:0]} << byte_sh);
                load_word   = is_unsigned ? {24'h0, ld_byte} : {{24{ld_byte[7]}}, ld_byte};
            end
            SZ_HALF: begin
                merged_word = (rd_word & ~(32'h0000_FFFF << half_sh))
                            | ({16'h0, st_data[15:0]} << half_sh);
                load_word   = is_unsigned ? {16'h0, ld_half} : {{16{ld_half[15]}}, ld_half};
            end
            default: ;
        endcase
    end

endmodule

// File: rtl/mips_load_store_unit.sv
// rtl/mips_load_store_unit.sv - memory-stage load/store FSM driving a word-addressed data memory
module mips_load_store_unit
    import mips_lsu_pkg::*;
#(
    parameter int MEM_WORDS = 256
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_write,
    input  logic [1:0]  req_size,
    input  logic        req_unsigned,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_wdata,
    output logic        resp_valid,
    output logic [31:0] resp_rdata,
    output logic        resp_error,
    output logic [31:0] mem_add,
    output logic [31:0] mem_data_write,
    output logic        mem_write,
    input  logic [31:0] mem_data_read
);

    localparam logic [31:0] MEM_WORDS_W = 32'(MEM_WORDS);

    lsu_state_e  state_q, state_d;
    logic        write_q, write_d;
    logic [1:0]  size_q, size_d;
    logic        uns_q, uns_d;
    logic [1:0]  off_q, off_d;
    logic        err_q, err_d;
    logic [31:0] wdata_q, wdata_d;
    logic [31:0] rdata_q, rdata_d;
    logic [31:0] mem_add_q, mem_add_d;
    logic [31:0] mem_wdata_q, mem_wdata_d;
    logic        mem_write_q, mem_write_d;

    logic [31:0] req_index;
    logic        req_err;
    logic        accept;
    logic [31:0] merged_word;
    logic [31:0] load_word;

    assign req_index = {2'b00, req_addr[31:2]};
    assign req_ready = (state_q == ST_IDLE) && !reset;
    assign accept    = req_valid && req_ready;

    always_comb begin
        req_err = 1'b0;
        if (req_size == 2'b11)
            req_err = 1'b1;
        else if (req_size == SZ_HALF && req_addr[0])
            req_err = 1'b1;
        else if (req_size == SZ_WORD && req_addr[1:0] != 2'b00)
            req_err = 1'b1;
        else if (req_index >= MEM_WORDS_W)
            req_err = 1'b1;
    end

    mips_lsu_lane u_lane (
        .size        (size_q),
        .offset      (off_q),
        .is_unsigned (uns_q),
        .rd_word     (mem_data_read),
        .st_data     (wdata_q),
        .merged_word (merged_word),
        .load_word   (load_word)
    );

    always_comb begin
        state_d     = state_q;
        write_d     = write_q;
        size_d      = size_q;
        uns_d       = uns_q;
        off_d       = off_q;
        err_d       = err_q;
        wdata_d     = wdata_q;
        rdata_d     = rdata_q;
        mem_add_d   = mem_add_q;
        mem_wdata_d = mem_wdata_q;
        mem_write_d = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (accept) begin
                    write_d = req_write;
                    size_d  = req_size;
                    uns_d   = req_unsigned;
                    off_d   = req_addr[1:0];
                    err_d   = req_err;
                    wdata_d = req_wdata;
                    rdata_d = 32'h0;
                    if (req_err) begin
                        state_d = ST_RESP;
                    end else begin
                        mem_add_d = req_index;
                        if (req_write && req_size == SZ_WORD) begin
                            mem_wdata_d = req_wdata;
                            mem_write_d = 1'b1;
                            state_d     = ST_WRITE;
                        end else begin
                            state_d = ST_READ;
                        end
                    end
                end
            end
            ST_READ: begin
                // Sub-word stores read-modify-write; the merged word is held until RESP ends.
                if (write_q) begin
                    mem_wdata_d = merged_word;
                    mem_write_d = 1'b1;
                    state_d     = ST_WRITE;
                end else begin
                    rdata_d = load_word;
                    state_d = ST_RESP;
                end
            end
            ST_WRITE: state_d = ST_RESP;
            ST_RESP:  state_d = ST_IDLE;
            default:  state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= ST_IDLE;
            write_q     <= 1'b0;
            size_q      <= SZ_BYTE;
            uns_q       <= 1'b0;
            off_q       <= 2'b00;
            err_q       <= 1'b0;
            wdata_q     <= 32'h0;
            rdata_q     <= 32'h0;
            mem_add_q   <= 32'h0;
            mem_wdata_q <= 32'h0;
            mem_write_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            write_q     <= write_d;
            size_q      <= size_d;
            uns_q       <= uns_d;
            off_q       <= off_d;
            err_q       <= err_d;
            wdata_q     <= wdata_d;
            rdata_q     <= rdata_d;
            mem_add_q   <= mem_add_d;
            mem_wdata_q <= mem_wdata_d;
            mem_write_q <= mem_write_d;
        end
    end

    assign resp_valid     = (state_q == ST_RESP);
    assign resp_error     = resp_valid && err_q;
    assign resp_rdata     = resp_valid ? rdata_q : 32'h0;
    assign mem_add        = mem_add_q;
    assign mem_data_write = mem_wdata_q;
    assign mem_write      = mem_write_q;

endmodule
